fire_layer_sequencer: RTL and testbench
=======================================

FIRE_LAYER_SEQUENCER -- requirements
Module: fire_layer_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_LAYERS, default 4: number of layers sequenced, in index order 0..NUM_LAYERS-1.
REQ-002 The block SHALL have parameter WOUT, default 8: output width per layer; WOUT**2 is the expected sample count.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 65535: watchdog limit in clk cycles.
REQ-004 Port clk SHALL be an input of width 1: the single clock; all logic is on its rising edge.
REQ-005 Port rst SHALL be an input of width 1: asynchronous, active-low reset.
REQ-006 Port start SHALL be an input of width 1: begins a sequence; honoured only in IDLE.
REQ-007 Port abort SHALL be an input of width 1: synchronous abort to IDLE.
REQ-008 Port layer_finish SHALL be an input of width NUM_LAYERS: per-layer finish level.
REQ-009 Port layer_sample SHALL be an input of width NUM_LAYERS: per-layer one-cycle output-valid pulse.
REQ-010 Port layer_en SHALL be an output of width NUM_LAYERS: one-hot layer enable, or all zero.
REQ-011 Port ram_feedback SHALL be an output of width NUM_LAYERS: one-cycle acknowledge to the finished layer.
REQ-012 Port cur_layer SHALL be an output of width $clog2(NUM_LAYERS)+1: index of the active layer.
REQ-013 Port sample_cnt SHALL be an output of width $clog2(WOUT**2)+1: samples seen from the active layer.
REQ-014 Port busy SHALL be an output of width 1: high in every state except IDLE.
REQ-015 Port done SHALL be an output of width 1: one-cycle pulse at sequence completion.
REQ-016 Port count_err SHALL be an output of width 1: sticky flag; a layer finished with sample_cnt != WOUT**2.
REQ-017 Port timeout_err SHALL be an output of width 1: watchdog flag.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, RUN, ACK, DONE and ERR.
REQ-019 In IDLE, start=1 at edge t SHALL give RUN with cur_layer=0, layer_en[0]=1 and sample_cnt=0 at t+1.
REQ-020 In RUN, layer_en SHALL equal exactly 1<<cur_layer.
REQ-021 In RUN, each layer_sample[cur_layer] pulse SHALL increment sample_cnt, saturating at all-ones.
REQ-022 In RUN, layer_finish[cur_layer]=1 at edge t SHALL give ACK at t+1, with layer_en all zero and ram_feedback[cur_layer]=1 for exactly that cycle.
REQ-023 In the cycle layer_finish is sampled, count_err SHALL be set if sample_cnt (including any same-cycle sample) != WOUT**2.
REQ-024 From ACK, if cur_layer < NUM_LAYERS-1 the FSM SHALL enter RUN with cur_layer+1 and sample_cnt=0; the next layer_en is therefore high at t+2.
REQ-025 From ACK, if cur_layer == NUM_LAYERS-1 the FSM SHALL enter DONE, pulse done for one cycle, then return to IDLE.
REQ-026 layer_finish and layer_sample bits of non-current layers SHALL be ignored.
REQ-027 start outside IDLE SHALL be ignored.
REQ-028 abort SHALL take the FSM from any state to IDLE at the next edge, clear layer_en, issue no ram_feedback and keep the error flags; abort has priority over every other event.
REQ-029 A layer_sample pulse and layer_finish in the same cycle SHALL both be taken: the sample is counted, then the transition to ACK occurs.
REQ-030 start=1 in IDLE SHALL clear count_err and timeout_err.

Reset
REQ-031 While rst=0 the block SHALL be in IDLE with layer_en=0, ram_feedback=0, cur_layer=0, sample_cnt=0, busy=0, done=0, count_err=0 and timeout_err=0, asynchronously.
REQ-032 Reset asserted mid-RUN SHALL drop layer_en immediately and issue no ram_feedback.

Configuration
REQ-033 With macro FIRE_SEQ_TIMEOUT_EN defined, a watchdog SHALL count cycles spent in RUN, restarting on every RUN entry.
REQ-034 With FIRE_SEQ_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL enter ERR with layer_en=0 and timeout_err=1, held until abort or reset.
REQ-035 Without FIRE_SEQ_TIMEOUT_EN, no watchdog logic SHALL exist, timeout_err SHALL be tied to 0, and ERR SHALL be unreachable.

Structure
REQ-036 Package fire_seq_pkg SHALL hold the state enum typedef and the default parameter constants.
REQ-037 The watchdog SHALL be the sub-module fire_seq_watchdog, with inputs clk, rst, clear and run and output expired; it is instantiated only under FIRE_SEQ_TIMEOUT_EN.

Verification
REQ-038 start pulse, each layer giving 64 samples then finish -> layer_en walks 1,2,4,8; each ram_feedback pulses once; done pulses once; count_err=0.
REQ-039 Layer 1 finishes after 63 samples -> count_err=1 and the sequence still completes with done.
REQ-040 abort asserted during RUN of layer 2 -> IDLE next cycle, layer_en=0, no ram_feedback[2].
REQ-041 layer_finish[3] asserted while cur_layer=1 -> no effect; layer_en stays 2.
REQ-042 With FIRE_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=100, no finish -> timeout_err=1 at RUN entry+100 and layer_en=0.
REQ-043 rst driven low mid-layer, then start -> all outputs at reset values, then layer_en[0]=1 one cycle after start.

Source files
------------

// File: rtl/fire_seq_pkg.sv
// Shared types and default parameters for the fire layer sequencer.
// The optional watchdog is enabled by defining FIRE_SEQ_TIMEOUT_EN.
package fire_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        ACK,
        DONE,
        ERR
    } state_t;

    localparam int unsigned DEF_NUM_LAYERS     = 4;
    localparam int unsigned DEF_WOUT           = 8;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 65535;

endpackage

// File: rtl/fire_seq_watchdog.sv
// Counts cycles spent in RUN and flags expiry at TIMEOUT_CYCLES.
// Instantiated by fire_layer_sequencer only when FIRE_SEQ_TIMEOUT_EN is defined.
module fire_seq_watchdog
    import fire_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // After k edges in RUN the count is k-1, so expiry is seen on edge TIMEOUT_CYCLES.
    assign expired = run && (cnt_q >= LIMIT);

    always_comb begin
        // NOTE: assign a default first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fire_layer_sequencer.sv
// Walks NUM_LAYERS layers in order, counting samples and acknowledging each finish.
// Define FIRE_SEQ_TIMEOUT_EN to add the RUN watchdog and the ERR state.
module fire_layer_sequencer
    import fire_seq_pkg::*;
#(
    parameter int unsigned NUM_LAYERS     = DEF_NUM_LAYERS,
    parameter int unsigned WOUT           = DEF_WOUT,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [NUM_LAYERS-1:0]         layer_finish,
    input  logic [NUM_LAYERS-1:0]         layer_sample,
    output logic [NUM_LAYERS-1:0]         layer_en,
    output logic [NUM_LAYERS-1:0]         ram_feedback,
    output logic [$clog2(NUM_LAYERS):0]   cur_layer,
    output logic [$clog2(WOUT*WOUT):0]    sample_cnt,
    output logic                          busy,
    output logic                          done,
    output logic                          count_err,
    output logic                          timeout_err
);

    localparam int unsigned CLW = $clog2(NUM_LAYERS) + 1;
    localparam int unsigned SCW = $clog2(WOUT * WOUT) + 1;
    localparam logic [SCW-1:0]        EXP_CNT    = SCW'(WOUT * WOUT);
    localparam logic [CLW-1:0]        LAST_LAYER = CLW'(NUM_LAYERS - 1);
    localparam logic [NUM_LAYERS-1:0] FIRST_EN   = NUM_LAYERS'(1);

    state_t                state_q;
    logic [NUM_LAYERS-1:0] layer_en_q;
    logic [NUM_LAYERS-1:0] ram_feedback_q;
    logic [CLW-1:0]        cur_layer_q;
    logic [SCW-1:0]        sample_cnt_q;
    logic                  done_q;
    logic                  count_err_q;

    logic                  cur_sample;
    logic                  cur_finish;
    logic [SCW-1:0]        cnt_seen;

    // layer_en_q is one-hot only in RUN, so masking with it ignores other layers.
    assign cur_sample = |(layer_sample & layer_en_q);
    assign cur_finish = |(layer_finish & layer_en_q);
    assign cnt_seen   = (cur_sample && !(&sample_cnt_q)) ? sample_cnt_q + 1'b1 : sample_cnt_q;

`ifdef FIRE_SEQ_TIMEOUT_EN
    logic wd_expired;
    logic timeout_err_q;

    fire_seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q != RUN),
        .run    (state_q == RUN),
        .expired(wd_expired)
    );

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            layer_en_q     <= '0;
            ram_feedback_q <= '0;
            cur_layer_q    <= '0;
            sample_cnt_q   <= '0;
            done_q         <= 1'b0;
            count_err_q    <= 1'b0;
`ifdef FIRE_SEQ_TIMEOUT_EN
            timeout_err_q  <= 1'b0;
`endif
        end else begin
            ram_feedback_q <= '0;
            done_q         <= 1'b0;
            if (abort) begin
                state_q    <= IDLE;
                layer_en_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q       <= RUN;
                            cur_layer_q   <= '0;
                            sample_cnt_q  <= '0;
                            layer_en_q    <= FIRST_EN;
                            count_err_q   <= 1'b0;
`ifdef FIRE_SEQ_TIMEOUT_EN
                            timeout_err_q <= 1'b0;
`endif
                        end
                    end
                    RUN: begin
`ifdef FIRE_SEQ_TIMEOUT_EN
                        if (wd_expired) begin
                            state_q       <= ERR;
                            layer_en_q    <= '0;
                            timeout_err_q <= 1'b1;
                        end else begin
`else
                        begin
`endif
                            sample_cnt_q <= cnt_seen;
                            if (cur_finish) begin
                                state_q        <= ACK;
                                layer_en_q     <= '0;
                                ram_feedback_q <= layer_en_q;
                                if (cnt_seen != EXP_CNT) begin
                                    count_err_q <= 1'b1;
                                end
                            end
                        end
                    end
                    ACK: begin
                        if (cur_layer_q == LAST_LAYER) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q      <= RUN;
                            cur_layer_q  <= cur_layer_q + 1'b1;
                            sample_cnt_q <= '0;
                            layer_en_q   <= ram_feedback_q << 1;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    ERR: begin
                        state_q <= ERR;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign layer_en     = layer_en_q;
    assign ram_feedback = ram_feedback_q;
    assign cur_layer    = cur_layer_q;
    assign sample_cnt   = sample_cnt_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign count_err    = count_err_q;

endmodule

// File: tb/tb_fire_layer_sequencer.sv
// Directed, table-driven bench for fire_layer_sequencer (NUM_LAYERS=4, WOUT=8, TIMEOUT_CYCLES=100).
// The watchdog sequence runs only when FIRE_SEQ_TIMEOUT_EN is defined.
module tb_fire_layer_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] layer_finish;
    logic [3:0] layer_sample;
    logic [3:0] layer_en;
    logic [3:0] ram_feedback;
    logic [2:0] cur_layer;
    logic [6:0] sample_cnt;
    logic       busy;
    logic       done;
    logic       count_err;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;

    fire_layer_sequencer #(
        .NUM_LAYERS    (4),
        .WOUT          (8),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .layer_finish(layer_finish),
        .layer_sample(layer_sample),
        .layer_en    (layer_en),
        .ram_feedback(ram_feedback),
        .cur_layer   (cur_layer),
        .sample_cnt  (sample_cnt),
        .busy        (busy),
        .done        (done),
        .count_err   (count_err),
        .timeout_err (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string      name;
        int         reps;
        logic       st;
        logic       ab;
        logic [3:0] fin;
        logic [3:0] smp;
        logic [3:0] en;
        logic [3:0] fb;
        int         cur;   // -1: not checked
        int         cnt;   // -1: not checked
        logic       busy;
        logic       done;
        logic       cerr;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic r(input string name, input int reps, input logic st, input logic ab,
                     input logic [3:0] fin, input logic [3:0] smp, input logic [3:0] en,
                     input logic [3:0] fb, input int cur, input int cnt, input logic bsy,
                     input logic dn, input logic cerr);
        vec_t v;
        v.name = name; v.reps = reps; v.st = st; v.ab = ab; v.fin = fin; v.smp = smp;
        v.en = en; v.fb = fb; v.cur = cur; v.cnt = cnt; v.busy = bsy; v.done = dn; v.cerr = cerr;
        tbl.push_back(v);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        layer_finish = '0; layer_sample = '0;

        //  name           reps st ab fin    smp    en     fb     cur cnt busy done cerr
        r("idle",          1,  0, 0, 4'h0, 4'h0, 4'h0, 4'h0,  0,  0, 0, 0, 0);
        r("a_start",       1,  1, 0, 4'h0, 4'h0, 4'h1, 4'h0,  0,  0, 1, 0, 0);
        r("a_l0_smp",      64, 0, 0, 4'h0, 4'h1, 4'h1, 4'h0,  0, 64, 1, 0, 0);
        r("a_l0_fin",      1,  0, 0, 4'h1, 4'h0, 4'h0, 4'h1,  0, 64, 1, 0, 0);
        r("a_l1_run",      1,  0, 0, 4'h0, 4'h0, 4'h2, 4'h0,  1,  0, 1, 0, 0);
        r("a_other_layer", 3,  0, 0, 4'h8, 4'h1, 4'h2, 4'h0,  1,  0, 1, 0, 0);
        r("a_l1_smp",      64, 0, 0, 4'h0, 4'h2, 4'h2, 4'h0,  1, 64, 1, 0, 0);
        r("a_l1_fin",      1,  0, 0, 4'h2, 4'h0, 4'h0, 4'h2,  1, 64, 1, 0, 0);
        r("a_l2_run",      1,  0, 0, 4'h0, 4'h0, 4'h4, 4'h0,  2,  0, 1, 0, 0);
        r("a_l2_smp",      63, 0, 0, 4'h0, 4'h4, 4'h4, 4'h0,  2, 63, 1, 0, 0);
        r("a_l2_fin_smp",  1,  0, 0, 4'h4, 4'h4, 4'h0, 4'h4,  2, 64, 1, 0, 0);
        r("a_l3_run",      1,  0, 0, 4'h0, 4'h0, 4'h8, 4'h0,  3,  0, 1, 0, 0);
        r("a_l3_smp_st",   64, 1, 0, 4'h0, 4'h8, 4'h8, 4'h0,  3, 64, 1, 0, 0);
        r("a_l3_fin",      1,  0, 0, 4'h8, 4'h0, 4'h0, 4'h8,  3, 64, 1, 0, 0);
        r("a_done",        1,  0, 0, 4'h0, 4'h0, 4'h0, 4'h0,  3, 64, 1, 1, 0);
        r("a_idle",        1,  0, 0, 4'h0, 4'h0, 4'h0, 4'h0, -1, -1, 0, 0, 0);
        r("a_idle2",       1,  0, 0, 4'h0, 4'h0, 4'h0, 4'h0, -1, -1, 0, 0, 0);
        r("b_start",       1,  1, 0, 4'h0, 4'h0, 4'h1, 4'h0,  0,  0, 1, 0, 0);
        r("b_l0_smp",      64, 0, 0, 4'h0, 4'h1, 4'h1, 4'h0,  0, 64, 1, 0, 0);
        r("b_l0_fin",      1,  0, 0, 4'h1, 4'h0, 4'h0, 4'h1,  0, 64, 1, 0, 0);
        r("b_l1_run",      1,  0, 0, 4'h0, 4'h0, 4'h2, 4'h0,  1,  0, 1, 0, 0);
        r("b_l1_smp",      63, 0, 0, 4'h0, 4'h2, 4'h2, 4'h0,  1, 63, 1, 0, 0);
        r("b_l1_fin_short",1,  0, 0, 4'h2, 4'h0, 4'h0, 4'h2,  1, 63, 1, 0, 1);
        r("b_l2_run",      1,  0, 0, 4'h0, 4'h0, 4'h4, 4'h0,  2,  0, 1, 0, 1);
        r("b_l2_smp",      64, 0, 0, 4'h0, 4'h4, 4'h4, 4'h0,  2, 64, 1, 0, 1);
        r("b_l2_fin",      1,  0, 0, 4'h4, 4'h0, 4'h0, 4'h4,  2, 64, 1, 0, 1);
        r("b_l3_run",      1,  0, 0, 4'h0, 4'h0, 4'h8, 4'h0,  3,  0, 1, 0, 1);
        r("b_l3_fin",      1,  0, 0, 4'h8, 4'h0, 4'h0, 4'h8,  3,  0, 1, 0, 1);
        r("b_done",        1,  0, 0, 4'h0, 4'h0, 4'h0, 4'h0,  3,  0, 1, 1, 1);
        r("b_idle",        1,  0, 0, 4'h0, 4'h0, 4'h0, 4'h0, -1, -1, 0, 0, 1);
        r("c_abort_start", 1,  1, 1, 4'h0, 4'h0, 4'h0, 4'h0, -1, -1, 0, 0, 1);
        r("c_start_clr",   1,  1, 0, 4'h0, 4'h0, 4'h1, 4'h0,  0,  0, 1, 0, 0);
        r("c_l0_smp",      10, 0, 0, 4'h0, 4'h1, 4'h1, 4'h0,  0, 10, 1, 0, 0);
        r("c_l0_fin",      1,  0, 0, 4'h1, 4'h0, 4'h0, 4'h1,  0, 10, 1, 0, 1);
        r("c_l1_run",      1,  0, 0, 4'h0, 4'h0, 4'h2, 4'h0,  1,  0, 1, 0, 1);
        r("c_l1_fin",      1,  0, 0, 4'h2, 4'h0, 4'h0, 4'h2,  1,  0, 1, 0, 1);
        r("c_l2_run",      1,  0, 0, 4'h0, 4'h0, 4'h4, 4'h0,  2,  0, 1, 0, 1);
        r("c_l2_smp",      5,  0, 0, 4'h0, 4'h4, 4'h4, 4'h0,  2,  5, 1, 0, 1);
        r("c_abort_l2",    1,  0, 1, 4'h4, 4'h4, 4'h0, 4'h0, -1, -1, 0, 0, 1);
        r("c_after_abort", 1,  0, 0, 4'h0, 4'h0, 4'h0, 4'h0, -1, -1, 0, 0, 1);
        r("c_restart",     1,  1, 0, 4'h0, 4'h0, 4'h1, 4'h0,  0,  0, 1, 0, 0);
        r("c_l0_part",     7,  0, 0, 4'h0, 4'h1, 4'h1, 4'h0,  0,  7, 1, 0, 0);

        // Reset values while rst is low.
        #1;
        check("rst_en", layer_en, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_terr", timeout_err, 1'b0);
        repeat (2) tick();
        rst = 1'b1;
        tick();

        foreach (tbl[i]) begin
            start        = tbl[i].st;
            abort        = tbl[i].ab;
            layer_finish = tbl[i].fin;
            layer_sample = tbl[i].smp;
            repeat (tbl[i].reps) tick();
            check({tbl[i].name, ".en"}, layer_en, tbl[i].en);
            check({tbl[i].name, ".fb"}, ram_feedback, tbl[i].fb);
            if (tbl[i].cur >= 0) check({tbl[i].name, ".cur"}, cur_layer, tbl[i].cur);
            if (tbl[i].cnt >= 0) check({tbl[i].name, ".cnt"}, sample_cnt, tbl[i].cnt);
            check({tbl[i].name, ".busy"}, busy, tbl[i].busy);
            check({tbl[i].name, ".done"}, done, tbl[i].done);
            check({tbl[i].name, ".cerr"}, count_err, tbl[i].cerr);
        end
        start = 1'b0; abort = 1'b0; layer_finish = '0; layer_sample = '0;

        // Asynchronous reset in the middle of layer 0 (cnt=7), then a fresh start.
        layer_sample = 4'h1;
        rst = 1'b0;
        #2;
        check("mid_rst_en", layer_en, 4'h0);
        check("mid_rst_fb", ram_feedback, 4'h0);
        check("mid_rst_cur", cur_layer, 3'd0);
        check("mid_rst_cnt", sample_cnt, 7'd0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_cerr", count_err, 1'b0);
        check("mid_rst_terr", timeout_err, 1'b0);
        layer_sample = 4'h0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_en", layer_en, 4'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_en", layer_en, 4'h1);
        check("restart_cur", cur_layer, 3'd0);
        check("restart_cnt", sample_cnt, 7'd0);

`ifdef FIRE_SEQ_TIMEOUT_EN
        // RUN entered on the start edge; expiry is due exactly 100 edges later.
        for (int k = 1; k <= 110; k++) begin
            tick();
            if (k == 99) begin
                check("wd_before_terr", timeout_err, 1'b0);
                check("wd_before_en", layer_en, 4'h1);
            end
            if (k == 100) begin
                check("wd_at_terr", timeout_err, 1'b1);
                check("wd_at_en", layer_en, 4'h0);
                check("wd_at_busy", busy, 1'b1);
                break;
            end
        end
        start = 1'b1;
        layer_finish = 4'h1;
        repeat (3) tick();
        start = 1'b0;
        layer_finish = 4'h0;
        check("err_hold_terr", timeout_err, 1'b1);
        check("err_hold_busy", busy, 1'b1);
        check("err_hold_fb", ram_feedback, 4'h0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("err_abort_busy", busy, 1'b0);
        check("err_abort_terr", timeout_err, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("err_start_terr", timeout_err, 1'b0);
        check("err_start_en", layer_en, 4'h1);
`else
        // Counter saturation after a long layer; no watchdog in this build.
        layer_sample = 4'h1;
        repeat (130) tick();
        layer_sample = 4'h0;
        check("sat_cnt", sample_cnt, 7'd127);
        check("sat_en", layer_en, 4'h1);
        check("no_wd_terr", timeout_err, 1'b0);
        layer_finish = 4'h1;
        tick();
        layer_finish = 4'h0;
        check("sat_fin_fb", ram_feedback, 4'h1);
        check("sat_fin_cerr", count_err, 1'b1);
`endif
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("end_idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
